booth_csa_seq: RTL
==================

Name: booth_csa_seq

Overview:
- Iterative signed WIDTHxWIDTH radix-4 Booth multiplier controller.
- Sequences one shared row of 4:2 compressors over the partial products, two Booth partial products per cycle, accumulating in carry-save form. One final carry-propagate add produces the result.
- Area-reduced alternative to the full jump Wallace tree, for low-throughput users. Valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, operand width; must be a multiple of 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  multiplicand, signed two's complement.
- b  in  WIDTH  multiplier, signed two's complement.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- p  out  2*WIDTH  signed product a*b.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset values:
  - state=IDLE; in_ready=1; out_valid=0; busy=0; p=0.
  - Operand, sum, carry and cnt registers are cleared.
- FSM states: IDLE, ACC, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, and latch {b,1'b0} as Booth source.
  - Clear sum/carry (2*WIDTH each) and set cnt=0. Go to ACC.
- ACC:
  - Each cycle, form Booth digits for groups j=2*cnt and j=2*cnt+1. Group j uses bits b[2j+1:2j-1], with b[-1]=0.
  - Digit encoding: {0,+1,+2,-1,-2}.
  - Each PP = digit*a, sign-extended to 2*WIDTH, then shifted left 2j. Negative multiples are formed as full two's complement (invert+1) inside the PP generator; there are no separate correction bits.
  - The compressor row takes {sum, carry, pp0, pp1} and produces new_sum and new_carry. new_carry is shifted left 1; all widths are truncated modulo 2^(2*WIDTH).
  - cnt increments each cycle. When cnt==WIDTH/4-1 the update completes and the FSM goes to ADD.
- ADD:
  - p <= sum+carry, modulo 2^(2*WIDTH). Go to DONE.
- DONE:
  - out_valid=1 and p is held stable.
  - On out_ready: go to IDLE and clear out_valid.
  - in_ready=0; new operands are not accepted in the same cycle.
- Latency: out_valid rises WIDTH/4+1 rising edges after the input handshake edge (9 for WIDTH=32).
- Throughput: one product per WIDTH/4+3 cycles at best.
- Backpressure: out_ready low holds DONE indefinitely; p and out_valid stay constant.
- Operand changes while busy are ignored; in_valid while busy is ignored and not queued.
- Reset asserted mid-operation aborts immediately. After deassertion the block is in IDLE with in_ready=1 and out_valid=0, and no partial result is emitted.
- p holds the last product after DONE until the next ADD writes it. Consumers must sample p only when out_valid=1.
- Corner operands need no special handling:
  - Most-negative values are exact, because PPs are full 2*WIDTH two's complement.
  - A zero operand still takes the full latency.

Decomposition:
- Shared package:
  - FSM state encoding.
  - Booth digit encoding constants.
  - Localparam NCYC=WIDTH/4 and counter width $clog2(NCYC).
- One sub-module, csa42_row: a purely combinational 2*WIDTH-bit row of the team's 4:2 compressor cells.
  - Inputs: sum, carry, pp0, pp1. Outputs: new_sum, new_carry.
  - Intra-row carries chain between adjacent bit positions.
- Booth PP generation stays in booth_csa_seq.

Test Plan:
- a=3, b=5 -> p=0x000000000000000F. out_valid rises exactly 9 edges after the handshake; busy high throughout.
- a=0xFFFFFFFF, b=0xFFFFFFFF (-1*-1) -> p=0x0000000000000001.
- a=0x80000000, b=0x80000000 -> p=0x4000000000000000. Also a=0x7FFFFFFF, b=0x80000000 -> p=0xC000000080000000.
- Backpressure: a=7, b=-6, out_ready low for 5 cycles after out_valid.
  - p=0xFFFFFFFFFFFFFFD6 holds stable, in_ready=0, and in_valid pulses are ignored.
  - Then out_ready=1 -> IDLE next cycle.
- Reset pulse in the 4th ACC cycle of a=0x12345678, b=0x9ABCDEF0.
  - out_valid never rises; after deassertion in_ready=1 and p=0.
  - The next op a=2, b=2 -> p=4.
- 10k random signed pairs, including 0, ±1 and the extremes, with random in_valid/out_ready gaps. Every p must match a 64-bit signed reference model and the latency must always be 9.

Source files
------------

// File: rtl/booth_csa_seq_pkg.sv
// Shared types for the iterative radix-4 Booth / carry-save multiplier:
// FSM encoding, Booth digit codes and the cycle-count helpers.
package booth_csa_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        ADD,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        BD_ZERO,
        BD_P1,
        BD_P2,
        BD_M1,
        BD_M2
    } booth_dig_e;

    localparam int DEF_WIDTH = 32;

    // Two Booth groups (four multiplier bits) are retired per cycle.
    function automatic int ncyc(input int w);
        return w / 4;
    endfunction

    function automatic int cnt_width(input int w);
        return (w / 4 > 1) ? $clog2(w / 4) : 1;
    endfunction

    localparam int NCYC  = ncyc(DEF_WIDTH);
    localparam int CNT_W = cnt_width(DEF_WIDTH);

    // Radix-4 recoding of the triplet {b[2j+1], b[2j], b[2j-1]}.
    function automatic booth_dig_e booth_enc(input logic [2:0] g);
        case (g)
            3'b001, 3'b010: return BD_P1;
            3'b011:         return BD_P2;
            3'b100:         return BD_M2;
            3'b101, 3'b110: return BD_M1;
            default:        return BD_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth_csa_seq_csa42_row.sv
// One row of 4:2 compressor cells (two chained full adders per bit); the
// cell-to-cell carry ripples one position only, so the row stays shallow.
module booth_csa_seq_csa42_row #(
    parameter int N = 64
) (
    input  logic [N-1:0] sum,
    input  logic [N-1:0] carry,
    input  logic [N-1:0] pp0,
    input  logic [N-1:0] pp1,
    output logic [N-1:0] new_sum,
    output logic [N-1:0] new_carry
);

    logic [N-1:0] s1;
    logic [N-1:0] cin;
    logic [N-2:0] cout;
    logic [N-2:0] c_lo;

    // The MSB cell's outgoing carries fall off the modulo-2^N result.
    assign s1   = sum ^ carry ^ pp0;
    assign cout = (sum[N-2:0] & carry[N-2:0]) | (sum[N-2:0] & pp0[N-2:0]) |
                  (carry[N-2:0] & pp0[N-2:0]);
    assign cin  = {cout, 1'b0};

    assign new_sum   = s1 ^ pp1 ^ cin;
    assign c_lo      = (s1[N-2:0] & pp1[N-2:0]) | (s1[N-2:0] & cin[N-2:0]) |
                       (pp1[N-2:0] & cin[N-2:0]);
    assign new_carry = {c_lo, 1'b0};

endmodule

// File: rtl/booth_csa_seq.sv
// Iterative signed radix-4 Booth multiplier: two partial products per cycle
// folded into a carry-save accumulator, then one carry-propagate add.
module booth_csa_seq
    import booth_csa_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;
    localparam int NC = ncyc(WIDTH);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [PW-1:0] ONE = PW'(1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH:0]    bsrc_q, bsrc_d;
    logic [PW-1:0]     sum_q, sum_d;
    logic [PW-1:0]     carry_q, carry_d;
    logic [PW-1:0]     p_q, p_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [4:0]        grp;
    logic [PW-1:0]     a_ext, pp0, pp1, new_sum, new_carry;

    // Full-width two's complement multiple, so no sign-correction bits are needed.
    function automatic logic [PW-1:0] pp_mult(input booth_dig_e dig, input logic [PW-1:0] ax);
        case (dig)
            BD_P1:   return ax;
            BD_P2:   return ax << 1;
            BD_M1:   return (~ax) + ONE;
            BD_M2:   return (~(ax << 1)) + ONE;
            default: return '0;
        endcase
    endfunction

    // bsrc carries the implicit b[-1]=0 at bit 0; groups 2*cnt and 2*cnt+1 overlap by one bit.
    always_comb begin
        grp   = bsrc_q[{cnt_q, 2'b00} +: 5];
        a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
        pp0   = pp_mult(booth_enc(grp[2:0]), a_ext) << {cnt_q, 2'b00};
        pp1   = pp_mult(booth_enc(grp[4:2]), a_ext) << {cnt_q, 2'b10};
    end

    booth_csa_seq_csa42_row #(.N(PW)) u_row (
        .sum       (sum_q),
        .carry     (carry_q),
        .pp0       (pp0),
        .pp1       (pp1),
        .new_sum   (new_sum),
        .new_carry (new_carry)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        bsrc_d  = bsrc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                bsrc_d  = {b, 1'b0};
                sum_d   = '0;
                carry_d = '0;
                cnt_d   = '0;
                state_d = ACC;
            end
            ACC: begin
                sum_d   = new_sum;
                carry_d = new_carry;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NC - 1)) state_d = ADD;
            end
            ADD: begin
                p_d     = sum_q + carry_q;
                state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            bsrc_q  <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            bsrc_q  <= bsrc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign p         = p_q;

endmodule
